// File: rtl/alu_uart_host_if.sv
// Request/response and UART-side signals of the ALU link host.
// The master modport is the host block; the slave modport is its environment.
interface alu_uart_host_if #(
  parameter int NB_DATA   = 8,
  parameter int NB_ALU_OP = 6
);
  logic                 i_req_valid;
  logic                 o_req_ready;
  logic [NB_DATA-1:0]   i_req_a;
  logic [NB_DATA-1:0]   i_req_b;
  logic [NB_ALU_OP-1:0] i_req_op;
  logic                 o_tx_start;
  logic [NB_DATA-1:0]   o_tx_data;
  logic                 i_tx_done;
  logic [NB_DATA-1:0]   i_rx_data;
  logic                 i_rx_done;
  logic                 o_resp_valid;
  logic [NB_DATA-1:0]   o_resp_data;
  logic                 o_timeout;

  modport master (
    input  i_req_valid, i_req_a, i_req_b, i_req_op, i_tx_done, i_rx_data, i_rx_done,
    output o_req_ready, o_tx_start, o_tx_data, o_resp_valid, o_resp_data, o_timeout
  );

  modport slave (
    output i_req_valid, i_req_a, i_req_b, i_req_op, i_tx_done, i_rx_data, i_rx_done,
    input  o_req_ready, o_tx_start, o_tx_data, o_resp_valid, o_resp_data, o_timeout
  );
endinterface

// File: rtl/alu_uart_host.sv
// Host-side initiator of the UART ALU link: sends A, B, op as three bytes,
// then waits for the one-byte result or aborts after a per-state timeout.
module alu_uart_host #(
  parameter int NB_DATA        = 8,
  parameter int NB_ALU_OP      = 6,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int NB_TIMEOUT     = 17
) (
  input  logic              i_clk,
  input  logic              i_reset,
  alu_uart_host_if.master   bus
);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_TX, WAIT_RX} state_t;

  localparam logic [NB_TIMEOUT-1:0] TERMINAL = NB_TIMEOUT'(TIMEOUT_CYCLES - 1);

  state_t               state_reg;
  logic [NB_DATA-1:0]   a_reg;
  logic [NB_DATA-1:0]   b_reg;
  logic [NB_ALU_OP-1:0] op_reg;
  logic [1:0]           idx_reg;
  logic [NB_TIMEOUT-1:0] cnt_reg;
  logic [NB_DATA-1:0]   op_ext;
  logic [NB_DATA-1:0]   next_byte;

  // Third wire byte is the opcode zero-extended to the byte width
  assign op_ext = NB_DATA'(op_reg);

  // Byte that follows the one currently in flight (index 0 -> B, index 1 -> op)
  always_comb begin
    next_byte = op_ext;
    if (idx_reg == 2'd0) next_byte = b_reg;
  end

  // Frame sequencer; every output is registered so it lines up with the state
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_reg        <= IDLE;
      a_reg            <= '0;
      b_reg            <= '0;
      op_reg           <= '0;
      idx_reg          <= 2'd0;
      cnt_reg          <= '0;
      bus.o_req_ready  <= 1'b1;
      bus.o_tx_start   <= 1'b0;
      bus.o_tx_data    <= '0;
      bus.o_resp_valid <= 1'b0;
      bus.o_resp_data  <= '0;
      bus.o_timeout    <= 1'b0;
    end else begin
      bus.o_tx_start   <= 1'b0;
      bus.o_resp_valid <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.i_req_valid && bus.o_req_ready) begin
            a_reg           <= bus.i_req_a;
            b_reg           <= bus.i_req_b;
            op_reg          <= bus.i_req_op;
            idx_reg         <= 2'd0;
            // Start pulse is raised on entry so SEND itself carries it
            bus.o_tx_start  <= 1'b1;
            bus.o_tx_data   <= bus.i_req_a;
            bus.o_req_ready <= 1'b0;
            state_reg       <= SEND;
          end
        end
        SEND: begin
          cnt_reg   <= '0;
          state_reg <= WAIT_TX;
        end
        WAIT_TX: begin
          // A done tick takes priority over the terminal count
          if (bus.i_tx_done) begin
            cnt_reg <= '0;
            if (idx_reg < 2'd2) begin
              idx_reg        <= idx_reg + 2'd1;
              bus.o_tx_start <= 1'b1;
              bus.o_tx_data  <= next_byte;
              state_reg      <= SEND;
            end else begin
              state_reg <= WAIT_RX;
            end
          end else if (cnt_reg == TERMINAL) begin
            bus.o_resp_valid <= 1'b1;
            bus.o_resp_data  <= '0;
            bus.o_timeout    <= 1'b1;
            bus.o_req_ready  <= 1'b1;
            state_reg        <= IDLE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        WAIT_RX: begin
          if (bus.i_rx_done) begin
            bus.o_resp_valid <= 1'b1;
            bus.o_resp_data  <= bus.i_rx_data;
            bus.o_timeout    <= 1'b0;
            bus.o_req_ready  <= 1'b1;
            state_reg        <= IDLE;
          end else if (cnt_reg == TERMINAL) begin
            bus.o_resp_valid <= 1'b1;
            bus.o_resp_data  <= '0;
            bus.o_timeout    <= 1'b1;
            bus.o_req_ready  <= 1'b1;
            state_reg        <= IDLE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_uart_host.sv
// Directed bench for alu_uart_host: one instance with a 50-cycle timeout,
// one with a 10-cycle timeout for the done-vs-terminal-count race.
module tb_alu_uart_host;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  alu_uart_host_if #(.NB_DATA(8), .NB_ALU_OP(6)) bus ();
  alu_uart_host_if #(.NB_DATA(8), .NB_ALU_OP(6)) bus10 ();

  alu_uart_host #(.NB_DATA(8), .NB_ALU_OP(6), .TIMEOUT_CYCLES(50), .NB_TIMEOUT(17)) dut (
    .i_clk(clk), .i_reset(rst), .bus(bus.master)
  );

  alu_uart_host #(.NB_DATA(8), .NB_ALU_OP(6), .TIMEOUT_CYCLES(10), .NB_TIMEOUT(17)) dut10 (
    .i_clk(clk), .i_reset(rst), .bus(bus10.master)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_tx();
    bus.i_tx_done = 1'b1;
    tick();
    bus.i_tx_done = 1'b0;
  endtask

  task automatic pulse_rx(input logic [7:0] d);
    bus.i_rx_data = d;
    bus.i_rx_done = 1'b1;
    tick();
    bus.i_rx_done = 1'b0;
  endtask

  task automatic request(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    bus.i_req_a = a;
    bus.i_req_b = b;
    bus.i_req_op = op;
    bus.i_req_valid = 1'b1;
    tick();
    bus.i_req_valid = 1'b0;
  endtask

  initial begin
    logic seen;
    bus.i_req_valid = 0; bus.i_req_a = 0; bus.i_req_b = 0; bus.i_req_op = 0;
    bus.i_tx_done = 0; bus.i_rx_data = 0; bus.i_rx_done = 0;
    bus10.i_req_valid = 0; bus10.i_req_a = 0; bus10.i_req_b = 0; bus10.i_req_op = 0;
    bus10.i_tx_done = 0; bus10.i_rx_data = 0; bus10.i_rx_done = 0;

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_ready", 32'(bus.o_req_ready), 32'd1);
    chk("rst_tx_start", 32'(bus.o_tx_start), 32'd0);
    chk("rst_tx_data", 32'(bus.o_tx_data), 32'h00);
    chk("rst_resp_valid", 32'(bus.o_resp_valid), 32'd0);
    chk("rst_resp_data", 32'(bus.o_resp_data), 32'h00);
    chk("rst_timeout", 32'(bus.o_timeout), 32'd0);

    // 1: normal frame 05, 03, 20 -> response 08
    request(8'h05, 8'h03, 6'b100000);
    chk("t1_start0", 32'(bus.o_tx_start), 32'd1);
    chk("t1_data0", 32'(bus.o_tx_data), 32'h05);
    chk("t1_ready_low", 32'(bus.o_req_ready), 32'd0);
    tick();
    chk("t1_start0_single", 32'(bus.o_tx_start), 32'd0);
    tick();
    chk("t1_data0_hold", 32'(bus.o_tx_data), 32'h05);
    pulse_tx();
    chk("t1_start1", 32'(bus.o_tx_start), 32'd1);
    chk("t1_data1", 32'(bus.o_tx_data), 32'h03);
    tick();
    chk("t1_start1_single", 32'(bus.o_tx_start), 32'd0);
    pulse_tx();
    chk("t1_start2", 32'(bus.o_tx_start), 32'd1);
    chk("t1_data2", 32'(bus.o_tx_data), 32'h20);
    tick();
    pulse_tx();
    chk("t1_no_early_resp", 32'(bus.o_resp_valid), 32'd0);
    tick();
    pulse_rx(8'h08);
    chk("t1_resp_valid", 32'(bus.o_resp_valid), 32'd1);
    chk("t1_resp_data", 32'(bus.o_resp_data), 32'h08);
    chk("t1_timeout", 32'(bus.o_timeout), 32'd0);
    chk("t1_ready_back", 32'(bus.o_req_ready), 32'd1);
    tick();
    chk("t1_resp_single", 32'(bus.o_resp_valid), 32'd0);
    chk("t1_resp_hold", 32'(bus.o_resp_data), 32'h08);

    // 4: stray rx_done during WAIT_TX of byte1 is ignored, then real 3C
    request(8'h12, 8'h34, 6'b000001);
    tick();
    pulse_tx();
    tick();
    pulse_rx(8'hAA);
    chk("t4_stray_ignored", 32'(bus.o_resp_valid), 32'd0);
    pulse_tx();
    chk("t4_data2", 32'(bus.o_tx_data), 32'h01);
    tick();
    pulse_tx();
    tick();
    pulse_rx(8'h3C);
    chk("t4_resp_valid", 32'(bus.o_resp_valid), 32'd1);
    chk("t4_resp_data", 32'(bus.o_resp_data), 32'h3C);
    tick();

    // 2: timeout in WAIT_RX after 50 cycles, with 3: back-to-back request held
    request(8'h07, 8'h02, 6'b000000);
    tick();
    pulse_tx();
    tick();
    pulse_tx();
    tick();
    pulse_tx();
    seen = 1'b0;
    for (int i = 0; i < 49; i++) begin
      tick();
      if (bus.o_resp_valid) seen = 1'b1;
    end
    chk("t2_no_early_timeout", 32'(seen), 32'd0);
    bus.i_req_a = 8'hFF; bus.i_req_b = 8'h01; bus.i_req_op = 6'b100010;
    bus.i_req_valid = 1'b1;
    tick();
    chk("t2_resp_valid", 32'(bus.o_resp_valid), 32'd1);
    chk("t2_timeout", 32'(bus.o_timeout), 32'd1);
    chk("t2_resp_data", 32'(bus.o_resp_data), 32'h00);
    chk("t2_ready", 32'(bus.o_req_ready), 32'd1);
    chk("t3_not_taken_early", 32'(bus.o_tx_start), 32'd0);
    tick();
    bus.i_req_valid = 1'b0;
    chk("t3_start", 32'(bus.o_tx_start), 32'd1);
    chk("t3_data", 32'(bus.o_tx_data), 32'hFF);
    tick();
    pulse_tx();
    chk("t3_data1", 32'(bus.o_tx_data), 32'h01);
    tick();
    pulse_tx();
    chk("t3_data2", 32'(bus.o_tx_data), 32'h22);
    tick();
    pulse_tx();
    pulse_rx(8'h5A);
    chk("t3_resp_data", 32'(bus.o_resp_data), 32'h5A);
    chk("t3_timeout_clr", 32'(bus.o_timeout), 32'd0);
    tick();

    // 5: reset during WAIT_TX of byte1
    request(8'h11, 8'h22, 6'b000011);
    tick();
    pulse_tx();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_tx_start", 32'(bus.o_tx_start), 32'd0);
    chk("t5_ready", 32'(bus.o_req_ready), 32'd1);
    chk("t5_tx_data", 32'(bus.o_tx_data), 32'h00);
    seen = bus.o_resp_valid;
    bus.i_tx_done = 1'b1;
    bus.i_rx_data = 8'h77;
    bus.i_rx_done = 1'b1;
    tick();
    bus.i_tx_done = 1'b0;
    bus.i_rx_done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (bus.o_resp_valid || bus.o_tx_start) seen = 1'b1;
      tick();
    end
    chk("t5_no_resp", 32'(seen), 32'd0);
    chk("t5_resp_data_rst", 32'(bus.o_resp_data), 32'h00);

    // 6: tx_done coinciding with terminal count (10) advances the frame
    bus10.i_req_a = 8'h0A; bus10.i_req_b = 8'h0B; bus10.i_req_op = 6'h0C;
    bus10.i_req_valid = 1'b1;
    tick();
    bus10.i_req_valid = 1'b0;
    chk("t6_data0", 32'(bus10.o_tx_data), 32'h0A);
    tick();
    for (int i = 0; i < 9; i++) tick();
    bus10.i_tx_done = 1'b1;
    tick();
    bus10.i_tx_done = 1'b0;
    chk("t6_advance", 32'(bus10.o_tx_start), 32'd1);
    chk("t6_data1", 32'(bus10.o_tx_data), 32'h0B);
    chk("t6_no_timeout", 32'(bus10.o_resp_valid), 32'd0);
    // Same instance without a done tick: timeout after exactly 10 cycles
    tick();
    seen = 1'b0;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (bus10.o_resp_valid) seen = 1'b1;
    end
    chk("t6_no_early_timeout", 32'(seen), 32'd0);
    tick();
    chk("t6_timeout_valid", 32'(bus10.o_resp_valid), 32'd1);
    chk("t6_timeout_flag", 32'(bus10.o_timeout), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/alu_uart_host.md
Name: alu_uart_host

Overview:
Host-side command initiator for the UART ALU link. It accepts one ALU request (operand A, operand B, opcode) over a valid/ready handshake and serialises it as three bytes through the UART transmitter's start/done handshake. It then waits for the one-byte result from the UART receiver and returns that result, or flags a timeout. It sits between a test/host controller and the tx_mod/rx_mod pair, and is the initiating end of the protocol that the ALU-side interface answers.

Parameters:
NB_DATA, 8, UART byte width and operand/result width
NB_ALU_OP, 6, opcode width; must be <= NB_DATA
TIMEOUT_CYCLES, 100000, clock cycles allowed per wait state before abort
NB_TIMEOUT, 17, timeout counter width; 2^NB_TIMEOUT must be > TIMEOUT_CYCLES

Ports:
i_clk  in  1  system clock
i_reset  in  1  synchronous, active-high reset
i_req_valid  in  1  request present
o_req_ready  out  1  block can accept a request
i_req_a  in  NB_DATA  operand A
i_req_b  in  NB_DATA  operand B
i_req_op  in  NB_ALU_OP  ALU opcode
o_tx_start  out  1  one-cycle pulse; transmitter starts a byte
o_tx_data  out  NB_DATA  byte to transmit; valid when o_tx_start=1
i_tx_done  in  1  transmitter byte-complete tick
i_rx_data  in  NB_DATA  received byte
i_rx_done  in  1  receiver byte-complete tick
o_resp_valid  out  1  one-cycle pulse; response available
o_resp_data  out  NB_DATA  ALU result; 0 on timeout
o_timeout  out  1  qualifies o_resp_valid; 1 means aborted

Behaviour:
- Single clock domain: i_clk. Reset: i_reset, synchronous, active-high.
- Reset values: state IDLE, o_req_ready=1, o_tx_start=0, o_tx_data=0, o_resp_valid=0, o_resp_data=0, o_timeout=0, byte index=0, timeout counter=0.
- Wire order is fixed: byte0=A, byte1=B, byte2={(NB_DATA-NB_ALU_OP) zeros, op}. The response is one byte.
- States: IDLE, SEND, WAIT_TX, WAIT_RX.
- IDLE: o_req_ready=1. When i_req_valid & o_req_ready are both high, latch A, B and op, set index=0, and go to SEND. o_req_ready drops the next cycle.
- SEND: lasts exactly one cycle. o_tx_start=1, o_tx_data=byte[index]. Next state is WAIT_TX. o_tx_data holds its value until the next SEND.
- WAIT_TX: on i_tx_done, if index<2 then index+1 and go to SEND; else go to WAIT_RX.
- WAIT_RX: on i_rx_done, register o_resp_data<=i_rx_data, o_timeout<=0 and o_resp_valid<=1 (visible the next cycle), and go to IDLE.
- o_resp_valid is high for exactly one cycle, which is also the first IDLE cycle (o_req_ready=1). A new request may be accepted in that cycle.
- o_resp_data and o_timeout hold their values until the next response.
- Latency from accept to first o_tx_start: 1 cycle. From i_rx_done to o_resp_valid: 1 cycle.
- Timeout counter: cleared on entry to WAIT_TX and WAIT_RX. It increments each cycle in those states.
- When the counter reaches TIMEOUT_CYCLES-1 with no done tick: go to IDLE and pulse o_resp_valid with o_timeout=1 and o_resp_data=0. The partial frame is abandoned.
- Done tick and timeout terminal count in the same cycle: the done tick wins.
- i_rx_done seen in IDLE, SEND or WAIT_TX is ignored (stale or unsolicited byte).
- i_tx_done seen outside WAIT_TX is ignored.
- i_req_valid while not ready: ignored. The request is not latched and the requester must hold it.
- Reset mid-operation: returns to IDLE on the next edge, all outputs at reset values, and no o_resp_valid is produced for the aborted request.

Test Plan:
1. A=8'h05, B=8'h03, op=6'b100000, with a bench responder that returns 8'h08 → o_tx_data sequence 05, 03, 20, each with a single-cycle o_tx_start. Then o_resp_valid pulses once with o_resp_data=08 and o_timeout=0.
2. TIMEOUT_CYCLES=50, responder never sends i_rx_done → 50 cycles after entering WAIT_RX, o_resp_valid=1, o_timeout=1, o_resp_data=00, o_req_ready=1.
3. Back-to-back: a second request (A=8'hFF, B=8'h01, op=6'b100010) is held valid during the o_resp_valid cycle → it is accepted in that cycle and the first o_tx_start (data FF) follows 1 cycle later.
4. Inject i_rx_done with i_rx_data=8'hAA during WAIT_TX of byte1 → it is ignored. The frame completes, and the real response 8'h3C is reported.
5. Assert i_reset for one cycle during WAIT_TX of byte1 → next cycle: IDLE, o_tx_start=0, o_req_ready=1, and no o_resp_valid.
6. i_tx_done and the timeout terminal count in the same cycle (TIMEOUT_CYCLES=10) → the frame advances to the next SEND, and no timeout is reported.
